// File: rtl/datapath_reg_storage.sv
// Register storage for the bus CPU datapath: GPRs R0..R(NUM_REGS-1) with R0 base-address gating, plus MDR.
// Optional build macro REG_WRITE_COUNT_EN adds a 16-bit wr_count output counting cycles with any load.
module datapath_reg_storage #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
) (
  input  logic                       clk,
  input  logic                       clr,
  input  logic [DATA_W-1:0]          bus_in,
  input  logic [NUM_REGS-1:0]        reg_in,
  input  logic                       ba_out,
  output logic [NUM_REGS*DATA_W-1:0] reg_q,
  input  logic                       mdr_in,
  input  logic                       read,
  input  logic [DATA_W-1:0]          mdata_in,
  output logic [DATA_W-1:0]          mdr_q
`ifdef REG_WRITE_COUNT_EN
  ,
  output logic [15:0]                wr_count
`endif
);

  logic [DATA_W-1:0] gpr_r [NUM_REGS];
  logic [DATA_W-1:0] mdr_r;
  logic [DATA_W-1:0] mdr_d_s;

  // GPR storage: clr wins over every load enable
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        gpr_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (reg_in[i]) begin
          gpr_r[i] <= bus_in;
        end
      end
    end
  end

  // MDR source select: memory data when reading, otherwise the bus
  always_comb begin
    mdr_d_s = bus_in;
    if (read) begin
      mdr_d_s = mdata_in;
    end else begin
      mdr_d_s = bus_in;
    end
  end

  // MDR storage
  always_ff @(posedge clk) begin
    if (clr) begin
      mdr_r <= {DATA_W{1'b0}};
    end else if (mdr_in) begin
      mdr_r <= mdr_d_s;
    end else begin
      mdr_r <= mdr_r;
    end
  end

  assign mdr_q = mdr_r;

  // Flatten GPRs; R0 reads as zero while ba_out selects base-address mode, its stored value untouched
  always_comb begin
    reg_q = {(NUM_REGS*DATA_W){1'b0}};
    for (int i = 1; i < NUM_REGS; i++) begin
      reg_q[DATA_W*i +: DATA_W] = gpr_r[i];
    end
    if (ba_out) begin
      reg_q[DATA_W-1:0] = {DATA_W{1'b0}};
    end else begin
      reg_q[DATA_W-1:0] = gpr_r[0];
    end
  end

`ifdef REG_WRITE_COUNT_EN
  logic [15:0] wr_count_r;

  // One increment per cycle with any load enable, wrapping naturally at 16 bits
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_count_r <= 16'd0;
    end else if ((|reg_in) || mdr_in) begin
      wr_count_r <= wr_count_r + 16'd1;
    end else begin
      wr_count_r <= wr_count_r;
    end
  end

  assign wr_count = wr_count_r;
`endif

endmodule

// File: tb/tb_datapath_reg_storage.sv
// Self-checking bench for datapath_reg_storage: directed steps plus random traffic against an array model.
module tb_datapath_reg_storage;
  localparam int DW = 32;
  localparam int NR = 16;

  logic               clk = 1'b0;
  logic               clr = 1'b0;
  logic [DW-1:0]      bus_in = 32'd0;
  logic [NR-1:0]      reg_in = 16'd0;
  logic               ba_out = 1'b0;
  logic [NR*DW-1:0]   reg_q;
  logic               mdr_in = 1'b0;
  logic               read = 1'b0;
  logic [DW-1:0]      mdata_in = 32'd0;
  logic [DW-1:0]      mdr_q;
`ifdef REG_WRITE_COUNT_EN
  logic [15:0]        wr_count;
`endif

  datapath_reg_storage #(.DATA_W(DW), .NUM_REGS(NR)) dut (
    .clk(clk), .clr(clr), .bus_in(bus_in), .reg_in(reg_in), .ba_out(ba_out),
    .reg_q(reg_q), .mdr_in(mdr_in), .read(read), .mdata_in(mdata_in), .mdr_q(mdr_q)
`ifdef REG_WRITE_COUNT_EN
    , .wr_count(wr_count)
`endif
  );

  always #5 clk = ~clk;

  // Reference model
  logic [DW-1:0] m_reg [NR];
  logic [DW-1:0] m_mdr;
  logic [15:0]   m_cnt;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [DW-1:0] e;
    for (int i = 0; i < NR; i++) begin
      e = (i == 0 && ba_out) ? 32'd0 : m_reg[i];
      chk($sformatf("%s_R%0d", tag, i), reg_q[DW*i +: DW], e);
    end
    chk({tag, "_MDR"}, mdr_q, m_mdr);
`ifdef REG_WRITE_COUNT_EN
    chk({tag, "_CNT"}, {16'd0, wr_count}, {16'd0, m_cnt});
`endif
  endtask

  // Drive one cycle of inputs on the falling edge, advance the model at the rising edge
  task automatic apply(input logic c, input logic [NR-1:0] ri, input logic mi,
                       input logic rd, input logic [DW-1:0] b, input logic [DW-1:0] md);
    @(negedge clk);
    clr = c; reg_in = ri; mdr_in = mi; read = rd; bus_in = b; mdata_in = md;
    @(posedge clk);
    if (c) begin
      for (int i = 0; i < NR; i++) m_reg[i] = 32'd0;
      m_mdr = 32'd0;
      m_cnt = 16'd0;
    end else begin
      for (int i = 0; i < NR; i++) if (ri[i]) m_reg[i] = b;
      if (mi) m_mdr = rd ? md : b;
      if (ri != 16'd0 || mi) m_cnt = m_cnt + 16'd1;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < NR; i++) m_reg[i] = 32'd0;
    m_mdr = 32'd0;
    m_cnt = 16'd0;

    // Reset with every enable high
    apply(1'b1, 16'hFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF);
    check_all("reset");

    // GPR load and hold
    apply(1'b0, 16'h0020, 1'b0, 1'b0, 32'hDEADBEEF, 32'd0);
    check_all("r5_load");
    apply(1'b0, 16'h0000, 1'b0, 1'b0, 32'h00000000, 32'd0);
    check_all("r5_hold");

    // R0 gating, no clock between toggles
    apply(1'b0, 16'h0001, 1'b0, 1'b0, 32'h12345678, 32'd0);
    check_all("r0_load");
    ba_out = 1'b1; #1;
    chk("r0_ba1", reg_q[DW-1:0], 32'h00000000);
    ba_out = 1'b0; #1;
    chk("r0_ba0", reg_q[DW-1:0], 32'h12345678);
    ba_out = 1'b1;
    apply(1'b0, 16'h0000, 1'b0, 1'b0, 32'h0, 32'd0);
    check_all("r0_ba_hold");
    ba_out = 1'b0; #1;
    check_all("r0_ba_release");

    // MDR source select and hold
    apply(1'b0, 16'h0000, 1'b1, 1'b1, 32'h11111111, 32'hCAFEF00D);
    check_all("mdr_mem");
    apply(1'b0, 16'h0000, 1'b1, 1'b0, 32'h000000FF, 32'hCAFEF00D);
    check_all("mdr_bus");
    apply(1'b0, 16'h0000, 1'b0, 1'b1, 32'h77777777, 32'h55555555);
    check_all("mdr_hold");

    // Multi-enable, then reset priority over a same-cycle load, then post-reset load
    apply(1'b0, 16'h000C, 1'b0, 1'b0, 32'hA5A5A5A5, 32'd0);
    check_all("multi");
    apply(1'b1, 16'h0004, 1'b1, 1'b0, 32'h00000001, 32'd0);
    check_all("clr_prio");
    apply(1'b0, 16'h0004, 1'b0, 1'b0, 32'h00000002, 32'd0);
    check_all("post_clr");

`ifdef REG_WRITE_COUNT_EN
    apply(1'b1, 16'h0000, 1'b0, 1'b0, 32'd0, 32'd0);
    apply(1'b0, 16'h0002, 1'b0, 1'b0, 32'h1, 32'd0);
    apply(1'b0, 16'h0000, 1'b0, 1'b0, 32'h2, 32'd0);
    apply(1'b0, 16'h0300, 1'b0, 1'b0, 32'h3, 32'd0);
    apply(1'b0, 16'h0000, 1'b1, 1'b0, 32'h4, 32'd0);
    chk("cnt_three", {16'd0, wr_count}, 32'd3);
`endif

    // Random traffic
    for (int n = 0; n < 300; n++) begin
      logic [NR-1:0] ri;
      ri = 16'($urandom) & 16'($urandom) & 16'($urandom);
      ba_out = 1'($urandom);
      apply(($urandom_range(0, 15) == 0), ri, 1'($urandom), 1'($urandom),
            32'($urandom), 32'($urandom));
      check_all($sformatf("rand%0d", n));
    end
    ba_out = 1'b0;

`ifdef REG_WRITE_COUNT_EN
    // Drive the counter to its top value, then one more write wraps it
    while (m_cnt != 16'hFFFF) begin
      apply(1'b0, 16'h0010, 1'b0, 1'b0, 32'h0BAD0BAD, 32'd0);
    end
    chk("cnt_max", {16'd0, wr_count}, 32'h0000FFFF);
    apply(1'b0, 16'h0000, 1'b1, 1'b0, 32'h00000042, 32'd0);
    chk("cnt_wrap", {16'd0, wr_count}, 32'h00000000);
    check_all("cnt_final");
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
